ttl_decoder_seq: RTL and testbench

TTL_DECODER_SEQ -- requirements
Module: ttl_decoder_seq

---
 rtl/ttl_decoder_seq_if.sv | 25 ++
 rtl/ttl_decoder_seq.sv | 172 +++++++++++++++++
 tb/tb_ttl_decoder_seq.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ttl_decoder_seq_if.sv
// ttl_decoder_seq_if -- bus bundle for the sequenced TTL-style decoder.
//   cen      : clock enable, state advances only on cen=1 clock edges
//   n_e      : active-low enable, one bit per channel
//   a        : address, ABITS per channel
//   mode     : 2 bits per channel (00 level, 01 one-shot, 10 scan, 11 level)
//   o        : active-low decoded outputs, 2^ABITS per channel
//   busy     : one-shot pulse in progress, one bit per channel
//   scan_idx : current scan index, ABITS per channel
interface ttl_decoder_seq_if #(
    parameter int CHANNELS = 2,
    parameter int ABITS    = 2
);
    localparam int OW = 1 << ABITS;

    logic                        cen;
    logic [CHANNELS-1:0]         n_e;
    logic [CHANNELS*ABITS-1:0]   a;
    logic [2*CHANNELS-1:0]       mode;
    logic [CHANNELS*OW-1:0]      o;
    logic [CHANNELS-1:0]         busy;
    logic [CHANNELS*ABITS-1:0]   scan_idx;

    modport master (output cen, n_e, a, mode, input o, busy, scan_idx);
    modport slave  (input cen, n_e, a, mode, output o, busy, scan_idx);
endinterface

// File: rtl/ttl_decoder_seq.sv
// ttl_decoder_seq -- multi-channel active-low decoder with level, one-shot
// and scan modes. Every output is a flop; nothing passes combinationally
// from inputs to outputs.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high, overrides cen and all inputs
//   bus   : ttl_decoder_seq_if slave (cen, n_e, a, mode -> o, busy, scan_idx)

// One decoder channel. Instantiated once per channel by the top.
module ttl_decoder_ch #(
    parameter int ABITS      = 2,
    parameter int STROBE_LEN = 4,
    parameter int SCAN_DIV   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cen_i,
    input  logic                  n_e_i,
    input  logic [ABITS-1:0]      a_i,
    input  logic [1:0]            mode_i,
    output logic [(1<<ABITS)-1:0] o_o,
    output logic                  busy_o,
    output logic [ABITS-1:0]      idx_o
);
    localparam int OW = 1 << ABITS;
    localparam int SW = $clog2(STROBE_LEN + 1);
    localparam int DW = $clog2(SCAN_DIV + 1);

    localparam logic [OW-1:0] ONES = {OW{1'b1}};

    logic [OW-1:0]    o_q, o_d;
    logic             busy_q, busy_d;
    logic [SW-1:0]    cnt_q, cnt_d;    // one-shot ticks remaining, incl. current
    logic [ABITS-1:0] idx_q, idx_d;
    logic [DW-1:0]    div_q, div_d;
    logic             prev_q, prev_d;  // n_e seen on the previous cen tick
    logic [1:0]       mode_q, mode_d;

    logic             trig;
    logic [ABITS-1:0] idx_nxt;

    function automatic logic [OW-1:0] dec(input logic [ABITS-1:0] sel);
        dec = ~(OW'(1) << sel);
    endfunction

    always_comb begin
        o_d     = o_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        div_d   = div_q;
        prev_d  = prev_q;
        mode_d  = mode_q;
        trig    = !n_e_i && prev_q;
        idx_nxt = idx_q;

        if (cen_i) begin
            mode_d = mode_i;
            prev_d = n_e_i;
            if (mode_i != mode_q) begin
                // Quiet tick. prev is left alone so that an enable already
                // low when one-shot mode takes over (e.g. held across reset)
                // still reads as a falling edge on the next tick.
                o_d    = ONES;
                busy_d = 1'b0;
                cnt_d  = '0;
                idx_d  = '0;
                div_d  = '0;
                prev_d = prev_q;
            end else begin
                case (mode_i)
                    2'b01: begin
                        if (busy_q && cnt_q != SW'(1)) begin
                            // mid-pulse: address and enable are ignored
                            cnt_d = cnt_q - SW'(1);
                        end else if (trig) begin
                            // idle, or last pulse tick: restart without a gap
                            o_d    = dec(a_i);
                            busy_d = 1'b1;
                            cnt_d  = SW'(STROBE_LEN);
                        end else begin
                            o_d    = ONES;
                            busy_d = 1'b0;
                            cnt_d  = '0;
                        end
                    end
                    2'b10: begin
                        if (n_e_i) begin
                            o_d   = ONES;
                            idx_d = '0;
                            div_d = '0;
                        end else begin
                            if (div_q == DW'(SCAN_DIV - 1)) begin
                                div_d   = '0;
                                idx_nxt = idx_q + ABITS'(1);
                            end else begin
                                div_d   = div_q + DW'(1);
                            end
                            idx_d = idx_nxt;
                            o_d   = dec(idx_nxt);
                        end
                    end
                    default: begin
                        o_d = n_e_i ? ONES : dec(a_i);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_q    <= ONES;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            idx_q  <= '0;
            div_q  <= '0;
            prev_q <= 1'b1;
            mode_q <= 2'b00;
        end else begin
            o_q    <= o_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            div_q  <= div_d;
            prev_q <= prev_d;
            mode_q <= mode_d;
        end
    end

    assign o_o    = o_q;
    assign busy_o = busy_q;
    assign idx_o  = idx_q;
endmodule

module ttl_decoder_seq #(
    parameter int CHANNELS   = 2,
    parameter int ABITS      = 2,
    parameter int STROBE_LEN = 4,
    parameter int SCAN_DIV   = 8
) (
    input logic               clk,
    input logic               reset,
    ttl_decoder_seq_if.slave  bus
);
    localparam int OW = 1 << ABITS;

    logic [CHANNELS-1:0][OW-1:0]    o_w;
    logic [CHANNELS-1:0]            busy_w;
    logic [CHANNELS-1:0][ABITS-1:0] idx_w;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        ttl_decoder_ch #(
            .ABITS     (ABITS),
            .STROBE_LEN(STROBE_LEN),
            .SCAN_DIV  (SCAN_DIV)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .cen_i (bus.cen),
            .n_e_i (bus.n_e[c]),
            .a_i   (bus.a[c*ABITS +: ABITS]),
            .mode_i(bus.mode[2*c +: 2]),
            .o_o   (o_w[c]),
            .busy_o(busy_w[c]),
            .idx_o (idx_w[c])
        );
    end

    assign bus.o        = o_w;
    assign bus.busy     = busy_w;
    assign bus.scan_idx = idx_w;
endmodule

// File: tb/tb_ttl_decoder_seq.sv
// Directed bench for ttl_decoder_seq at default parameters (2 channels,
// ABITS=2, STROBE_LEN=4, SCAN_DIV=8). The stimulus process queues the
// expected outputs after each clock edge; the monitor pops and compares
// them on the following falling edge.
module tb_ttl_decoder_seq;
    logic clk;
    logic reset;

    ttl_decoder_seq_if #(.CHANNELS(2), .ABITS(2)) bus ();

    ttl_decoder_seq #(
        .CHANNELS(2), .ABITS(2), .STROBE_LEN(4), .SCAN_DIV(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        string      nm;
        logic [7:0] o;
        logic [1:0] b;
        logic [3:0] i;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (bus.o !== e.o || bus.busy !== e.b || bus.scan_idx !== e.i) begin
                    errors++;
                    $display("FAIL %s: got o=%h busy=%b idx=%h, want o=%h busy=%b idx=%h",
                             e.nm, bus.o, bus.busy, bus.scan_idx, e.o, e.b, e.i);
                end
            end
        end
    end

    task automatic drv(input logic c, input logic [1:0] ne, input logic [3:0] aa,
                       input logic [3:0] md, input logic rst);
        bus.cen  = c;
        bus.n_e  = ne;
        bus.a    = aa;
        bus.mode = md;
        reset    = rst;
    endtask

    task automatic tick(input string nm, input logic [7:0] eo,
                        input logic [1:0] eb, input logic [3:0] ei);
        exp_t e;
        @(posedge clk);
        e.nm = nm; e.o = eo; e.b = eb; e.i = ei;
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] idx;
        logic [3:0] one;
        one = 4'b0001;

        // reset, with cen low to show reset does not need cen
        drv(0, 2'b11, 4'h0, 4'h0, 1);
        tick("reset0", 8'hFF, 2'b00, 4'h0);
        tick("reset1", 8'hFF, 2'b00, 4'h0);

        // level mode
        drv(1, 2'b11, 4'h0, 4'h0, 0);
        tick("lvl_idle", 8'hFF, 2'b00, 4'h0);
        drv(1, 2'b10, 4'b0010, 4'h0, 0);
        tick("lvl_ch0_a2", 8'hFB, 2'b00, 4'h0);
        drv(1, 2'b00, 4'b0111, 4'h0, 0);
        tick("lvl_both", 8'hD7, 2'b00, 4'h0);
        drv(1, 2'b11, 4'b0111, 4'h0, 0);
        tick("lvl_off", 8'hFF, 2'b00, 4'h0);

        // one-shot on ch1 (mode = ch1:01 ch0:00)
        drv(1, 2'b11, 4'h0, 4'b0100, 0);
        tick("os_modechg", 8'hFF, 2'b00, 4'h0);
        drv(1, 2'b01, 4'b1100, 4'b0100, 0);
        tick("os_t0", 8'h7F, 2'b10, 4'h0);
        drv(1, 2'b11, 4'b1100, 4'b0100, 0);
        tick("os_t1_ne_high", 8'h7F, 2'b10, 4'h0);
        drv(1, 2'b01, 4'b0000, 4'b0100, 0);
        tick("os_t2_refall", 8'h7F, 2'b10, 4'h0);
        tick("os_t3", 8'h7F, 2'b10, 4'h0);
        tick("os_end", 8'hFF, 2'b00, 4'h0);
        tick("os_held_low", 8'hFF, 2'b00, 4'h0);

        // back-to-back: trigger on the last pulse tick restarts with no gap
        drv(1, 2'b11, 4'h0, 4'b0100, 0);
        tick("b2b_rearm", 8'hFF, 2'b00, 4'h0);
        drv(1, 2'b01, 4'b0100, 4'b0100, 0);
        tick("b2b_p1_t0", 8'hDF, 2'b10, 4'h0);
        drv(1, 2'b11, 4'b0100, 4'b0100, 0);
        tick("b2b_p1_t1", 8'hDF, 2'b10, 4'h0);
        tick("b2b_p1_t2", 8'hDF, 2'b10, 4'h0);
        tick("b2b_p1_t3", 8'hDF, 2'b10, 4'h0);
        drv(1, 2'b01, 4'b1000, 4'b0100, 0);
        tick("b2b_p2_t0", 8'hBF, 2'b10, 4'h0);
        tick("b2b_p2_t1", 8'hBF, 2'b10, 4'h0);
        tick("b2b_p2_t2", 8'hBF, 2'b10, 4'h0);
        tick("b2b_p2_t3", 8'hBF, 2'b10, 4'h0);
        tick("b2b_end", 8'hFF, 2'b00, 4'h0);

        // cen gating: pulse spans 4 cen ticks; ch0 level request on cen=0 is held off
        drv(1, 2'b11, 4'h0, 4'b0100, 0);
        tick("cg_rearm", 8'hFF, 2'b00, 4'h0);
        drv(1, 2'b01, 4'b1100, 4'b0100, 0);
        tick("cg_t0", 8'h7F, 2'b10, 4'h0);
        for (int i = 0; i < 4; i++) begin
            drv(0, 2'b00, 4'b1101, 4'b0100, 0);
            tick("cg_hold", 8'h7F, 2'b10, 4'h0);
            drv(1, 2'b01, 4'b1100, 4'b0100, 0);
            if (i < 3) tick("cg_pulse", 8'h7F, 2'b10, 4'h0);
            else       tick("cg_end", 8'hFF, 2'b00, 4'h0);
        end
        drv(0, 2'b00, 4'b1101, 4'b0100, 0);
        tick("cg_hold_end", 8'hFF, 2'b00, 4'h0);

        // reset mid-pulse, n_e held low through release
        drv(1, 2'b11, 4'h0, 4'b0100, 0);
        tick("rp_rearm", 8'hFF, 2'b00, 4'h0);
        drv(1, 2'b01, 4'b1100, 4'b0100, 0);
        tick("rp_t0", 8'h7F, 2'b10, 4'h0);
        tick("rp_t1", 8'h7F, 2'b10, 4'h0);
        drv(0, 2'b01, 4'b1100, 4'b0100, 1);
        tick("rp_reset", 8'hFF, 2'b00, 4'h0);
        drv(1, 2'b01, 4'b1100, 4'b0100, 0);
        tick("rp_modechg", 8'hFF, 2'b00, 4'h0);
        tick("rp_new_t0", 8'h7F, 2'b10, 4'h0);
        tick("rp_new_t1", 8'h7F, 2'b10, 4'h0);
        tick("rp_new_t2", 8'h7F, 2'b10, 4'h0);
        tick("rp_new_t3", 8'h7F, 2'b10, 4'h0);
        tick("rp_new_end", 8'hFF, 2'b00, 4'h0);

        // scan on ch0 (mode = ch1:01 ch0:10); a is ignored
        drv(1, 2'b11, 4'h0, 4'b0110, 0);
        tick("sc_modechg", 8'hFF, 2'b00, 4'h0);
        for (int k = 1; k <= 34; k++) begin
            idx = 2'((k / 8) % 4);
            drv(1, 2'b10, 4'(k), 4'b0110, 0);
            tick("sc_step", {4'hF, ~(one << idx)}, 2'b00, {2'b00, idx});
        end
        drv(1, 2'b11, 4'h0, 4'b0110, 0);
        tick("sc_off", 8'hFF, 2'b00, 4'h0);

        // scanning at idx 2, then switch ch0 to level, then to 11 (also level)
        for (int k = 1; k <= 16; k++) begin
            idx = 2'((k / 8) % 4);
            drv(1, 2'b10, 4'h0, 4'b0110, 0);
            tick("ms_scan", {4'hF, ~(one << idx)}, 2'b00, {2'b00, idx});
        end
        drv(1, 2'b10, 4'b0001, 4'b0100, 0);
        tick("ms_chg", 8'hFF, 2'b00, 4'h0);
        tick("ms_lvl", 8'hFD, 2'b00, 4'h0);
        drv(1, 2'b10, 4'b0001, 4'b0111, 0);
        tick("ms_11chg", 8'hFF, 2'b00, 4'h0);
        tick("ms_11lvl", 8'hFD, 2'b00, 4'h0);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
